seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width in bits.
REQ-002 Parameter SLICE, default 16: bits processed per cycle; WIDTH % SLICE == 0 and SLICE >= 1 SHALL hold, else elaboration error.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request; sampled on rising edge of clk.
REQ-006 op  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-007 a  in  WIDTH  operand A, two's complement.
REQ-008 b  in  WIDTH  operand B, two's complement.
REQ-009 busy  out  1  high while a computation is in progress.
REQ-010 done  out  1  one-cycle pulse: result and cc valid.
REQ-011 result  out  WIDTH  computed value; held until next accepted start.
REQ-012 cc  out  3  condition codes {ZF, SF, OF}, same hold rule as result.

Function
REQ-013 Operations: ADD result = b + a; SUB result = b - a; AND result = a & b; XOR result = a ^ b; all mod 2^WIDTH.
REQ-014 FSM states IDLE, RUN, DONE; N = WIDTH/SLICE.
REQ-015 Start accepted on an edge where start=1 and state is IDLE or DONE; a, b, op latched, slice counter cleared, state -> RUN.
REQ-016 start=1 while state is RUN SHALL be ignored; no latched operand or op changes.
REQ-017 In RUN, each edge computes one SLICE-bit slice, LSB slice first, carry/borrow chained between slices; SUB implemented as b + ~a + 1 (carry-in 1 on slice 0).
REQ-018 After N RUN edges, state -> DONE; done=1 and busy=0 for exactly that one cycle; acceptance-to-done latency is N cycles (4 at defaults, 1 when SLICE==WIDTH).
REQ-019 DONE -> IDLE on next edge if start=0; DONE -> RUN (new operation) if start=1, done deasserting.
REQ-020 busy=1 exactly in RUN.
REQ-021 ZF = (result == 0); SF = result[WIDTH-1].
REQ-022 OF for ADD = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]); for SUB = (a[MSB]!=b[MSB]) && (result[MSB]!=b[MSB]); 0 for AND/XOR.
REQ-023 result and cc SHALL update only on the edge entering DONE; partial slices invisible on outputs during RUN.
REQ-024 Input changes on a, b, op while busy SHALL NOT affect the operation in flight.

Reset
REQ-025 rst_n=0 SHALL immediately, without clk, force state IDLE, busy=0, done=0, result=0, cc=3'b000, slice counter 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows; first start after rst_n rises behaves as a fresh start.
REQ-027 Start sampled on the first rising edge after rst_n deasserts SHALL be accepted.

Verification (defaults WIDTH=64, SLICE=16)
REQ-028 AND a=64'hB, b=64'h4 -> done 4 cycles after acceptance, result=0, cc={ZF=1,SF=0,OF=0}.
REQ-029 AND a=-11, b=12 -> result=4; XOR a=-2, b=-17 -> result=17, ZF=0, SF=0.
REQ-030 ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, {ZF,SF,OF}={0,1,1}; ADD a=64'hFFFF, b=1 -> result=64'h1_0000 (inter-slice carry).
REQ-031 SUB a=9, b=9 -> result=0, ZF=1; SUB a=1, b=0 -> result=-1 (all ones), SF=1, OF=0.
REQ-032 start pulsed during RUN with different operands -> ignored, original result delivered; start held high through DONE -> back-to-back op, done pulses every 5th cycle... no idle gap beyond DONE cycle.
REQ-033 rst_n low for 1 ns in 2nd RUN cycle -> busy, done, result, cc all 0 immediately; no done pulse until a new start; repeat with SLICE=WIDTH=64 confirming 1-cycle latency.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU (ADD/SUB/AND/XOR) that processes SLICE bits
//                per clock, LSB slice first, with the carry chained between
//                slices. Produces {ZF, SF, OF} condition codes with the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Reject slice widths that do not tile the operand exactly.
    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("seq_alu: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_a_op;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_full;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;

    // A new operation may start from IDLE or directly out of DONE.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CNT_W'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start during RUN is deliberately ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // One slice of arithmetic/logic; SUB is b + ~a with carry-in 1 on slice 0.
    always_comb begin
        w_a_sl  = r_a[r_cnt*SLICE +: SLICE];
        w_b_sl  = r_b[r_cnt*SLICE +: SLICE];
        w_a_op  = (r_op == OP_SUB) ? ~w_a_sl : w_a_sl;
        w_sum   = {1'b0, w_b_sl} + {1'b0, w_a_op} + {{SLICE{1'b0}}, r_carry};
        w_slice = w_sum[SLICE-1:0];
        case (r_op)
            OP_AND:  w_slice = w_a_sl & w_b_sl;
            OP_XOR:  w_slice = w_a_sl ^ w_b_sl;
            default: w_slice = w_sum[SLICE-1:0];
        endcase
        w_full = r_acc;
        w_full[r_cnt*SLICE +: SLICE] = w_slice;
    end

    // Condition codes of the full result as it stands after the current slice.
    always_comb begin
        w_zf = (w_full == '0);
        w_sf = w_full[WIDTH-1];
        w_of = 1'b0;
        case (r_op)
            OP_ADD:  w_of = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
            OP_SUB:  w_of = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_b[WIDTH-1]);
            default: w_of = 1'b0;
        endcase
    end

    // Operand capture, slice sequencing and result publication on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            result  <= '0;
            cc      <= 3'b000;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= (op == OP_SUB);
            r_acc   <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_full;
            r_carry <= w_sum[SLICE];
            if (w_last) begin
                r_cnt  <= '0;
                result <= w_full;
                cc     <= {w_zf, w_sf, w_of};
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu; a default 4-slice instance
//                and a single-slice instance, checked against a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 64;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [2:0]   cc;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] result;
    logic [2:0]   cc;

    logic         start_s = 1'b0;
    logic [1:0]   op_s = 2'b00;
    logic [W-1:0] a_s = '0;
    logic [W-1:0] b_s = '0;
    logic         busy_s, done_s;
    logic [W-1:0] result_s;
    logic [2:0]   cc_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+2:0] sb[$];
    logic [W-1:0] last_res;

    seq_alu #(.WIDTH(64), .SLICE(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cc(cc)
    );

    seq_alu #(.WIDTH(64), .SLICE(64)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .op(op_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .result(result_s), .cc(cc_s)
    );

    always #5 clk = ~clk;

    // Behavioural reference: packs {result, ZF, SF, OF}.
    function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic zf, sf, of;
        case (o)
            2'b00:   r = y + x;
            2'b01:   r = y - x;
            2'b10:   r = x & y;
            default: r = x ^ y;
        endcase
        zf = (r == '0);
        sf = r[W-1];
        of = 1'b0;
        if (o == 2'b00) of = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        if (o == 2'b01) of = (x[W-1] != y[W-1]) && (r[W-1] != y[W-1]);
        return {r, zf, sf, of};
    endfunction

    // Drive one request, push its expectation, scramble inputs after acceptance.
    task automatic issue(input bit sel, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W+2:0] exp);
        @(negedge clk);
        if (!sel) begin
            start = 1'b1; op = o; a = x; b = y;
        end else begin
            start_s = 1'b1; op_s = o; a_s = x; b_s = y;
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0; start_s = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 2'($urandom_range(0, 3));
        a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom}; op_s = 2'($urandom_range(0, 3));
    endtask

    // Count rising edges until done is seen (bounded).
    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (((sel ? done_s : done) !== 1'b1) && lat < 20);
    endtask

    task automatic test_reset;
        logic [W+2:0] exp;
        int lat;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        n_checks++; if (cc !== 3'b000) begin n_fail++; $display("FAIL reset_cc got=%b want=000", cc); end
        n_checks++; if (result_s !== '0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_s got res=%h busy=%b want 0/0", result_s, busy_s); end
        // Release reset and request on the very next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; op = 2'b10; a = -64'sd11; b = 64'd12;
        sb.push_back({64'd4, 3'b000});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat);
        exp = sb.pop_front();
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL first_edge_latency got=%0d want=4", lat); end
        n_checks++; if (result !== exp[W+2:3]) begin n_fail++; $display("FAIL first_edge_result got=%h want=%h", result, exp[W+2:3]); end
        n_checks++; if (cc !== exp[2:0]) begin n_fail++; $display("FAIL first_edge_cc got=%b want=%b", cc, exp[2:0]); end
        last_res = exp[W+2:3];
    endtask

    task automatic test_vectors;
        vec_t tbl [8] = '{
            '{2'b10, 64'hB, 64'h4, 64'h0, 3'b100},
            '{2'b10, -64'sd11, 64'd12, 64'd4, 3'b000},
            '{2'b11, -64'sd2, -64'sd17, 64'd17, 3'b000},
            '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011},
            '{2'b00, 64'hFFFF, 64'd1, 64'h1_0000, 3'b000},
            '{2'b01, 64'd9, 64'd9, 64'd0, 3'b100},
            '{2'b01, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010},
            '{2'b01, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001}
        };
        logic [W+2:0] exp;
        logic [W-1:0] x, y;
        logic [1:0] o;
        int lat;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                o = tbl[i].op; x = tbl[i].a; y = tbl[i].b;
                exp = {tbl[i].res, tbl[i].cc};
            end else begin
                o = 2'($urandom_range(0, 3)); x = {$urandom, $urandom}; y = {$urandom, $urandom};
                exp = model(o, x, y);
            end
            issue(1'b0, o, x, y, exp);
            n_checks++; if (busy !== 1'b1 || result !== last_res) begin n_fail++; $display("FAIL vec%0d_run busy=%b res=%h want busy=1 res=%h", i, busy, result, last_res); end
            wait_done(1'b0, lat);
            exp = sb.pop_front();
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL vec%0d_latency got=%0d want=4", i, lat); end
            n_checks++; if (result !== exp[W+2:3]) begin n_fail++; $display("FAIL vec%0d_result got=%h want=%h", i, result, exp[W+2:3]); end
            n_checks++; if (cc !== exp[2:0]) begin n_fail++; $display("FAIL vec%0d_cc got=%b want=%b", i, cc, exp[2:0]); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vec%0d_busy_done got=%b want=0", i, busy); end
            last_res = exp[W+2:3];
            @(posedge clk);
            #1;
            n_checks++; if (done !== 1'b0 || result !== last_res) begin n_fail++; $display("FAIL vec%0d_pulse done=%b res=%h want 0/%h", i, done, result, last_res); end
        end
    endtask

    task automatic test_ignore_start;
        logic [W+2:0] exp;
        logic [W-1:0] x, y;
        int lat;
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        issue(1'b0, 2'b00, x, y, model(2'b00, x, y));
        @(posedge clk);
        #1;
        start = 1'b1; a = ~x; b = ~y; op = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat);
        exp = sb.pop_front();
        n_checks++; if (lat + 2 !== 4) begin n_fail++; $display("FAIL ignore_latency got=%0d want=4", lat + 2); end
        n_checks++; if (result !== exp[W+2:3]) begin n_fail++; $display("FAIL ignore_result got=%h want=%h", result, exp[W+2:3]); end
        n_checks++; if (cc !== exp[2:0]) begin n_fail++; $display("FAIL ignore_cc got=%b want=%b", cc, exp[2:0]); end
        last_res = exp[W+2:3];
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [1:0]   vo [3] = '{2'b00, 2'b01, 2'b11};
        logic [W+2:0] exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b1; op = vo[0]; a = va[0]; b = vb[0];
        sb.push_back(model(vo[0], va[0], vb[0]));
        @(posedge clk);
        #1;
        op = vo[1]; a = va[1]; b = vb[1];
        sb.push_back(model(vo[1], va[1], vb[1]));
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b0, lat);
            exp = sb.pop_front();
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d want=4", k, lat); end
            n_checks++; if (result !== exp[W+2:3] || cc !== exp[2:0]) begin n_fail++; $display("FAIL b2b%0d_result got=%h/%b want=%h/%b", k, result, cc, exp[W+2:3], exp[2:0]); end
            @(posedge clk);
            #1;
            if (k < 2) begin
                n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_restart busy=%b done=%b want 1/0", k, busy, done); end
            end else begin
                n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy=%b done=%b want 0/0", busy, done); end
            end
            if (k == 0) begin
                op = vo[2]; a = va[2]; b = vb[2];
                sb.push_back(model(vo[2], va[2], vb[2]));
            end
            if (k == 1) start = 1'b0;
            last_res = exp[W+2:3];
        end
    endtask

    task automatic test_single_slice;
        logic [W+2:0] exp;
        logic [W-1:0] x, y;
        logic [1:0] o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin o = 2'b00; x = 64'h7FFF_FFFF_FFFF_FFFF; y = 64'd1; end
                1: begin o = 2'b01; x = 64'd1; y = 64'h8000_0000_0000_0000; end
                default: begin o = 2'($urandom_range(0, 3)); x = {$urandom, $urandom}; y = {$urandom, $urandom}; end
            endcase
            issue(1'b1, o, x, y, model(o, x, y));
            wait_done(1'b1, lat);
            exp = sb.pop_front();
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single%0d_latency got=%0d want=1", i, lat); end
            n_checks++; if (result_s !== exp[W+2:3] || cc_s !== exp[2:0]) begin n_fail++; $display("FAIL single%0d_result got=%h/%b want=%h/%b", i, result_s, cc_s, exp[W+2:3], exp[2:0]); end
            @(posedge clk);
            #1;
            n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("FAIL single%0d_pulse got=%b want=0", i, done_s); end
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W+2:0] exp;
        logic [W-1:0] x, y;
        int lat;
        int spurious;
        // Default instance: abort in the second RUN cycle.
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        issue(1'b0, 2'b11, x, y, model(2'b11, x, y));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #0.5;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cc !== 3'b000) begin n_fail++; $display("FAIL abort_outputs busy=%b done=%b res=%h cc=%b want all 0", busy, done, result, cc); end
        #0.5;
        rst_n = 1'b1;
        sb.delete();
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d bad cycles want=0", spurious); end
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        issue(1'b0, 2'b01, x, y, model(2'b01, x, y));
        wait_done(1'b0, lat);
        exp = sb.pop_front();
        n_checks++; if (lat !== 4 || result !== exp[W+2:3] || cc !== exp[2:0]) begin n_fail++; $display("FAIL abort_fresh lat=%0d res=%h cc=%b want 4/%h/%b", lat, result, cc, exp[W+2:3], exp[2:0]); end
        // Single-slice instance: abort inside its only RUN cycle.
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        issue(1'b1, 2'b00, x, y, model(2'b00, x, y));
        rst_n = 1'b0;
        #0.5;
        n_checks++; if (busy_s !== 1'b0 || done_s !== 1'b0 || result_s !== '0 || cc_s !== 3'b000) begin n_fail++; $display("FAIL abort_s_outputs busy=%b done=%b res=%h cc=%b want all 0", busy_s, done_s, result_s, cc_s); end
        #0.5;
        rst_n = 1'b1;
        sb.delete();
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_s !== 1'b0) spurious++;
        end
        n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL abort_s_no_done got=%0d bad cycles want=0", spurious); end
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        issue(1'b1, 2'b10, x, y, model(2'b10, x, y));
        wait_done(1'b1, lat);
        exp = sb.pop_front();
        n_checks++; if (lat !== 1 || result_s !== exp[W+2:3] || cc_s !== exp[2:0]) begin n_fail++; $display("FAIL abort_s_fresh lat=%0d res=%h cc=%b want 1/%h/%b", lat, result_s, cc_s, exp[W+2:3], exp[2:0]); end
    endtask

    initial begin
        last_res = '0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_single_slice();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
